// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetch with redirect, stall and optional jump pre-decode
// Ports: clk/rst (sync, active-high); rom_address/rom_instruction to a combinational
// instruction memory of ROM_DEPTH words; redirect_valid/redirect_pc restart fetch;
// out_valid/out_ready/out_instr/out_pc is the fetched-word handshake; fetch_err is a
// sticky out-of-range flag. Define FETCH_JUMP_PREDECODE_EN to follow direct jumps at fetch.
module instr_fetch #(
  parameter int ROM_DEPTH = 1001
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_err
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  localparam logic [31:0] DEPTH = 32'(ROM_DEPTH);
  localparam logic [31:0] LAST = 32'(ROM_DEPTH - 1);
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, out_instr_q, out_instr_d, out_pc_q, out_pc_d;
  logic out_valid_q, out_valid_d, fetch_err_q, fetch_err_d;
  logic [31:0] seq_pc, fetch_pc;
  logic fetch_oob, capture, redirect_oob;
  assign seq_pc = (pc_q == LAST) ? '0 : pc_q + 32'd1;
`ifdef FETCH_JUMP_PREDECODE_EN
  logic is_jump;
  logic [31:0] jump_pc;
  assign is_jump = rom_instruction[31:26] == 6'b000010;
  assign jump_pc = {pc_q[31:26], rom_instruction[25:0]};
  assign fetch_oob = is_jump && (jump_pc >= DEPTH);
  assign fetch_pc = is_jump ? (fetch_oob ? '0 : jump_pc) : seq_pc;
`else
  assign fetch_oob = 1'b0;
  assign fetch_pc = seq_pc;
`endif
  assign redirect_oob = redirect_pc >= DEPTH;
  assign capture = (state_q == RUN) && (!out_valid_q || out_ready);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    out_instr_d = out_instr_q;
    out_pc_d = out_pc_q;
    out_valid_d = out_valid_q;
    fetch_err_d = fetch_err_q;
    if (redirect_valid) begin
      state_d = FLUSH;
      pc_d = redirect_oob ? '0 : redirect_pc;
      out_valid_d = 1'b0;
      fetch_err_d = fetch_err_q | redirect_oob;
    end else if (state_q != RUN) begin
      state_d = RUN;
    end else if (capture) begin
      out_instr_d = rom_instruction;
      out_pc_d = pc_q;
      out_valid_d = 1'b1;
      pc_d = fetch_pc;
      fetch_err_d = fetch_err_q | fetch_oob;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= '0;
      out_instr_q <= '0;
      out_pc_q <= '0;
      out_valid_q <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      out_instr_q <= out_instr_d;
      out_pc_q <= out_pc_d;
      out_valid_q <= out_valid_d;
      fetch_err_q <= fetch_err_d;
    end
  end
  assign rom_address = pc_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc = out_pc_q;
  assign fetch_err = fetch_err_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch against a 1001-word instruction memory
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] rom_address, rom_instruction, redirect_pc, out_instr, out_pc;
  logic redirect_valid = 1'b0;
  logic out_ready = 1'b0;
  logic out_valid, fetch_err;
  logic [31:0] rom [0:1000];
  logic [31:0] sb [$];
  int checks = 0;
  int errors = 0;
  instr_fetch #(.ROM_DEPTH(1001)) dut (
    .clk(clk), .rst(rst), .rom_address(rom_address), .rom_instruction(rom_instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  assign rom_instruction = (rom_address < 32'd1001) ? rom[rom_address[9:0]] : 32'hdead_beef;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    logic [31:0] e;
    if (out_valid && out_ready && !rst && sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_pc", out_pc, e);
      check("sb_instr", out_instr, rom[e[9:0]]);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic drain(input string tag);
    check(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_pc"}, out_pc, 32'd0);
    check({tag, "_instr"}, out_instr, 32'd0);
    check({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
    check({tag, "_addr"}, rom_address, 32'd0);
  endtask
  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc = target;
    step();
    redirect_valid = 1'b0;
  endtask
  initial begin
    logic [31:0] jseq [4];
    for (int i = 0; i < 1001; i++) rom[i] = 32'h1000_0000 + 32'(i);
    rom[0] = 32'h2001_00ff;
    rom[1] = 32'h2002_02e9;
    rom[2] = 32'h0020_1820;
    rom[3] = 32'hac03_0000;
    rom[4] = 32'h0800_0000;
    redirect_pc = '0;
`ifdef FETCH_JUMP_PREDECODE_EN
    jseq = '{32'd3, 32'd4, 32'd0, 32'd1};
`else
    jseq = '{32'd3, 32'd4, 32'd5, 32'd6};
`endif
    out_ready = 1'b1;
    steps(3);
    check_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back(32'(i));
    step();
    check("r1_valid", {31'd0, out_valid}, 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_pc", out_pc, 32'(i));
      step();
    end
    drain("drain_stream");
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back(32'(i));
    steps(3);
    check("pre_stall_pc", out_pc, 32'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", out_pc, 32'd1);
      check("stall_instr", out_instr, 32'h2002_02e9);
      check("stall_addr", rom_address, 32'd2);
    end
    out_ready = 1'b1;
    step();
    check("release_pc", out_pc, 32'd2);
    step();
    check("post_release_pc", out_pc, 32'd3);
    redirect(32'd5);
    sb.push_back(32'd5);
    sb.push_back(32'd6);
    check("redir_n1_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("redir_n2_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("redir_n3_valid", {31'd0, out_valid}, 32'd1);
    check("redir_n3_pc", out_pc, 32'd5);
    check("redir_err", {31'd0, fetch_err}, 32'd0);
    step();
    redirect(32'd2000);
    sb.push_back(32'd0);
    sb.push_back(32'd1);
    check("oob_err", {31'd0, fetch_err}, 32'd1);
    check("oob_addr", rom_address, 32'd0);
    steps(2);
    check("oob_valid", {31'd0, out_valid}, 32'd1);
    check("oob_pc", out_pc, 32'd0);
    steps(2);
    check("oob_err_sticky", {31'd0, fetch_err}, 32'd1);
    drain("drain_oob");
    redirect(32'd10);
    redirect(32'd20);
    sb.push_back(32'd20);
    steps(2);
    check("reflush_valid", {31'd0, out_valid}, 32'd1);
    check("reflush_pc", out_pc, 32'd20);
    step();
    drain("drain_reflush");
    redirect(32'd7);
    rst = 1'b1;
    step();
    check_zero("rst_flush");
    rst = 1'b0;
    steps(2);
    check("restart_pc", out_pc, 32'd0);
    check("restart_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b0;
    steps(2);
    check("stall2_pc", out_pc, 32'd0);
    rst = 1'b1;
    step();
    check_zero("rst_stall");
    rst = 1'b0;
    out_ready = 1'b1;
    redirect(32'd999);
    sb.push_back(32'd999);
    sb.push_back(32'd1000);
    sb.push_back(32'd0);
    sb.push_back(32'd1);
    steps(2);
    check("wrap_first_pc", out_pc, 32'd999);
    steps(2);
    check("wrap_pc", out_pc, 32'd0);
    steps(2);
    drain("drain_wrap");
    redirect(32'd3);
    for (int i = 0; i < 4; i++) sb.push_back(jseq[i]);
    steps(2);
    for (int i = 0; i < 4; i++) begin
      check("jump_valid", {31'd0, out_valid}, 32'd1);
      check("jump_pc", out_pc, jseq[i]);
      step();
    end
    check("jump_err", {31'd0, fetch_err}, 32'd0);
    drain("drain_jump");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 1001, number of instruction words in the attached instruction memory.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rom_address  output  32  word index into instruction memory; combinationally equal to internal pc.
REQ-005 SHALL have port rom_instruction  input  32  word at rom_address, combinationally valid in the same cycle.
REQ-006 SHALL have port redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-007 SHALL have port redirect_pc  input  32  word-index redirect target.
REQ-008 SHALL have port out_valid  output  1  out_instr/out_pc hold a fetched instruction.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the word this cycle.
REQ-010 SHALL have port out_instr  output  32  fetched instruction.
REQ-011 SHALL have port out_pc  output  32  word index out_instr was fetched from.
REQ-012 SHALL have port fetch_err  output  1  sticky flag for an out-of-range redirect.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FLUSH; reset enters IDLE.
REQ-014 IDLE: no capture; SHALL move to RUN next cycle unless redirect_valid (then FLUSH).
REQ-015 RUN: when out_valid=0 or out_ready=1, SHALL capture rom_instruction into out_instr, pc into out_pc, set out_valid=1, advance pc.
REQ-016 RUN with out_valid=1 and out_ready=0: SHALL hold pc, out_instr, out_pc, out_valid unchanged (stall, no data loss).
REQ-017 pc advance SHALL be pc+1, wrapping to 0 when pc = ROM_DEPTH-1.
REQ-018 redirect_valid=1 in any state SHALL load pc with redirect_pc, clear out_valid next cycle, and enter FLUSH; redirect has highest priority.
REQ-019 redirect_pc >= ROM_DEPTH SHALL load pc=0 and set fetch_err=1; fetch_err clears only on rst.
REQ-020 FLUSH: SHALL perform no capture for one cycle, then enter RUN; a further redirect_valid in FLUSH restarts FLUSH with the new target.
REQ-021 Redirect latency: redirect_valid at cycle N SHALL yield out_valid=1 with out_pc=target at cycle N+3.
REQ-022 Redirect and out_ready in the same cycle: the word presented that cycle counts as accepted; no capture occurs that cycle.
REQ-023 Steady state with out_ready=1 SHALL deliver one instruction per cycle, out_pc incrementing by 1.

Reset
REQ-024 rst=1 SHALL set pc=0, state=IDLE, out_valid=0, out_instr=0, out_pc=0, fetch_err=0, overriding all other inputs including mid-stall and mid-FLUSH.
REQ-025 After rst falls at cycle R, first out_valid=1 with out_pc=0 SHALL appear at cycle R+2.

Configuration
REQ-026 Macro FETCH_JUMP_PREDECODE_EN SHALL control jump pre-decode.
REQ-027 With FETCH_JUMP_PREDECODE_EN defined, a captured word with bits[31:26]=6'b000010 SHALL set next pc={pc[31:26], word[25:0]} (word index; out-of-range handled as REQ-019) instead of pc+1, without a FLUSH cycle; redirect_valid still wins.
REQ-028 Without FETCH_JUMP_PREDECODE_EN, all captures SHALL advance per REQ-017; jumps are resolved only via redirect.

Verification
REQ-029 Reset release, out_ready=1, memory words 0..3 = 0x200100FF,0x200202E9,0x00201820,0xAC030000 -> out_pc 0,1,2,3 on consecutive cycles from R+2, out_instr matching.
REQ-030 out_ready=0 for 3 cycles while out_valid=1 at out_pc=1 -> out_instr/out_pc stable, rom_address stays 2; on release out_pc=2 next cycle.
REQ-031 redirect_valid with redirect_pc=5 at cycle N while out_ready=1 -> out_valid=0 at N+1,N+2; out_pc=5 at N+3; fetch_err=0.
REQ-032 redirect_pc=2000 with ROM_DEPTH=1001 -> pc=0, fetch_err=1 held until rst; next delivered out_pc=0.
REQ-033 Macro defined, word 4 = 0x08000000 -> out_pc sequence 3,4,0,1 with no bubble; macro undefined -> 3,4,5,6.
REQ-034 rst asserted during FLUSH and during stall -> all outputs zero next cycle; ROM_DEPTH-1 fetch wraps next out_pc to 0.
